// File: rtl/ecc_serial_frame_io_if.sv
// Bus bundle for the ECC serial framing front end: serial input frame,
// core start/done handshake and serial output frame.
interface ecc_serial_frame_io_if #(
  parameter int WIDTH     = 32,
  parameter int IN_LANES  = 4,
  parameter int OUT_LANES = 2
);
  // Serial input frame
  logic                          i_valid;
  logic                          i_mode;
  logic [IN_LANES-1:0]           i_bits;
  // Core handshake
  logic                          o_core_start;
  logic                          o_core_mode;
  logic [IN_LANES*WIDTH-1:0]     o_core_operands;
  logic                          i_core_done;
  logic [OUT_LANES*WIDTH-1:0]    i_core_result;
  // Serial output frame and status
  logic                          o_valid;
  logic [OUT_LANES-1:0]          o_bits;
  logic                          o_busy;
  logic                          o_err;

  // Framing block side
  modport slave (
    input  i_valid, i_mode, i_bits, i_core_done, i_core_result,
    output o_core_start, o_core_mode, o_core_operands,
           o_valid, o_bits, o_busy, o_err
  );

  // Driver side (serial source, core model, serial sink)
  modport master (
    output i_valid, i_mode, i_bits, i_core_done, i_core_result,
    input  o_core_start, o_core_mode, o_core_operands,
           o_valid, o_bits, o_busy, o_err
  );
endinterface

// File: rtl/ecc_serial_frame_io.sv
// Bit-serial framing front end for the ECC core.
// Deserialises IN_LANES operands MSB first, starts the core, waits for its
// result and reserialises OUT_LANES result lanes MSB first under o_valid.
// Short frames and frames arriving while busy raise a one-cycle o_err.
module ecc_serial_frame_io #(
  parameter int WIDTH     = 32,
  parameter int IN_LANES  = 4,
  parameter int OUT_LANES = 2
) (
  input  logic                 clk,
  input  logic                 rst,   // asynchronous, active low
  ecc_serial_frame_io_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;

  logic [2:0]                   state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [IN_LANES*WIDTH-1:0]    op_q, op_d, op_shift;
  logic [OUT_LANES*WIDTH-1:0]   res_q, res_d, res_shift, res_in;
  logic                         mode_q, mode_d;
  logic                         vin_q;
  logic                         start_q, valid_q, busy_q, err_q, err_d;
  logic [OUT_LANES-1:0]         obits_w;
  logic                         rise_w;
  logic                         last_w;

  // A frame begins only on a fresh rising edge of i_valid
  assign rise_w = bus.i_valid & ~vin_q;
  // Counter has reached the final bit position of the current phase
  assign last_w = (cnt_q == CW'(WIDTH - 1));

  // Per-lane shift paths: operands shift in at the LSB, results shift out at the MSB
  genvar gi;
  generate
    for (gi = 0; gi < IN_LANES; gi++) begin : g_in_lane
      assign op_shift[gi*WIDTH +: WIDTH] = {op_q[gi*WIDTH +: WIDTH-1], bus.i_bits[gi]};
    end
    for (gi = 0; gi < OUT_LANES; gi++) begin : g_out_lane
      assign res_shift[gi*WIDTH +: WIDTH] = {res_q[gi*WIDTH +: WIDTH-1], 1'b0};
      assign obits_w[gi]                  = res_q[gi*WIDTH + WIDTH-1];
      if (gi == 0) begin : g_lane0
        assign res_in[gi*WIDTH +: WIDTH] = bus.i_core_result[gi*WIDTH +: WIDTH];
      end else begin : g_lane_n
        // Shared-key mode carries only Pab on lane 0; the other lanes stream zeros
        assign res_in[gi*WIDTH +: WIDTH] = mode_q ? '0 : bus.i_core_result[gi*WIDTH +: WIDTH];
      end
    end
  endgenerate

  assign bus.o_core_start    = start_q;
  assign bus.o_core_mode     = mode_q;
  assign bus.o_core_operands = op_q;
  assign bus.o_valid         = valid_q;
  assign bus.o_bits          = obits_w;
  assign bus.o_busy          = busy_q;
  assign bus.o_err           = err_q;

  // Next-state logic for the frame FSM, counters and shift registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise_w) begin
          op_d    = op_shift;
          cnt_d   = CW'(1);
          mode_d  = bus.i_mode;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.i_valid) begin
          op_d  = op_shift;
          cnt_d = cnt_q + CW'(1);
          if (last_w) begin
            state_d = S_START;
          end
        end else begin
          // Frame ended early: report it and never start the core
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_START: begin
        err_d   = rise_w;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        err_d = rise_w;
        if (bus.i_core_done) begin
          res_d   = res_in;
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        err_d = rise_w;
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        if (last_w) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; async reset abandons any frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      mode_q  <= 1'b0;
      vin_q   <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
      vin_q   <= bus.i_valid;
      start_q <= (state_d == S_START);
      valid_q <= (state_d == S_SEND);
      busy_q  <= (state_d != S_IDLE);
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ecc_serial_frame_io.sv
// Directed bench for ecc_serial_frame_io: a vector table of nominal frames
// plus hand-written reset, short-frame, overlap, back-to-back and
// WIDTH=8 sequences. Inputs driven and outputs sampled on the falling edge.
module tb_ecc_serial_frame_io;
  localparam int W   = 32;
  localparam int NI  = 4;
  localparam int NO  = 2;
  localparam int W8  = 8;
  localparam int NI8 = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ecc_serial_frame_io_if #(.WIDTH(W),  .IN_LANES(NI),  .OUT_LANES(NO)) if32 ();
  ecc_serial_frame_io_if #(.WIDTH(W8), .IN_LANES(NI8), .OUT_LANES(NO)) if8 ();

  ecc_serial_frame_io #(.WIDTH(W), .IN_LANES(NI), .OUT_LANES(NO)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (if32.slave)
  );

  ecc_serial_frame_io #(.WIDTH(W8), .IN_LANES(NI8), .OUT_LANES(NO)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  int checks = 0;
  int errors = 0;
  int err32   = 0;
  int start32 = 0;

  typedef struct {
    string          name;
    logic           mode;
    logic [127:0]   ops;   // {a, y, x, p}
    logic [63:0]    res;   // {lane1, lane0} returned by the core model
    logic [63:0]    exp;   // {lane1, lane0} expected on o_bits
  } vec_t;

  vec_t vecs [4];

  // Pulse counters for o_err and o_core_start
  always @(negedge clk) begin
    if (if32.o_err)        err32++;
    if (if32.o_core_start) start32++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Drive one full frame, MSB first; returns on the falling edge after the last bit
  task automatic send_frame32(input logic mode, input logic [127:0] ops);
    for (int b = W - 1; b >= 0; b--) begin
      if32.i_valid = 1'b1;
      if32.i_mode  = mode;
      for (int k = 0; k < NI; k++) if32.i_bits[k] = ops[k*W + b];
      @(negedge clk);
    end
  endtask

  // Core model returns a result, then the serial output is collected and checked
  task automatic respond32(input string name, input logic [63:0] res, input logic [63:0] exp);
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    int n;
    int waitc;
    if32.i_core_done   = 1'b1;
    if32.i_core_result = res;
    @(negedge clk);
    if32.i_core_done   = 1'b0;
    if32.i_core_result = '0;
    check({name, " latency"}, if32.o_valid, 1'b1);
    waitc = 0;
    while (!if32.o_valid && waitc < 8) begin
      @(negedge clk);
      waitc++;
    end
    n  = 0;
    w0 = '0;
    w1 = '0;
    while (if32.o_valid && n < W + 8) begin
      w0 = {w0[W-2:0], if32.o_bits[0]};
      w1 = {w1[W-2:0], if32.o_bits[1]};
      n++;
      @(negedge clk);
    end
    check({name, " valid_len"}, n, W);
    check({name, " lane0"}, w0, exp[W-1:0]);
    check({name, " lane1"}, w1, exp[2*W-1:W]);
    check({name, " idle_after"}, if32.o_busy, 1'b0);
  endtask

  // Complete nominal transaction on the 32-bit instance
  task automatic nominal32(input vec_t v);
    int s0;
    s0 = start32;
    send_frame32(v.mode, v.ops);
    if32.i_valid = 1'b0;
    if32.i_bits  = '0;
    check({v.name, " start"}, if32.o_core_start, 1'b1);
    check({v.name, " operands"}, if32.o_core_operands, v.ops);
    check({v.name, " mode"}, if32.o_core_mode, v.mode);
    @(negedge clk);
    check({v.name, " start_1cyc"}, if32.o_core_start, 1'b0);
    respond32(v.name, v.res, v.exp);
    check({v.name, " start_count"}, start32 - s0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int s0;
    int seen;
    logic [15:0] ops8;
    logic [7:0]  w0;
    logic [7:0]  w1;
    int n;

    vecs[0] = '{"nominal_m0", 1'b0,
                {32'h00000005, 32'h0F0F0F0F, 32'h1234ABCD, 32'hFFFFFFFB},
                {32'h00C0FFEE, 32'h89ABCDEF}, {32'h00C0FFEE, 32'h89ABCDEF}};
    vecs[1] = '{"shared_m1", 1'b1,
                {32'hA5A5A5A5, 32'h00000000, 32'h00000001, 32'hFFFFFFFB},
                {32'h12345678, 32'hDEADBEEF}, {32'h00000000, 32'hDEADBEEF}};
    vecs[2] = '{"edges_m0", 1'b0,
                {32'h80000001, 32'h7FFFFFFE, 32'hFFFFFFFF, 32'h00000000},
                {32'h80000001, 32'hFFFFFFFF}, {32'h80000001, 32'hFFFFFFFF}};
    vecs[3] = '{"single_m0", 1'b0,
                {32'h00000000, 32'h00000001, 32'h80000000, 32'h55555555},
                {32'h00000001, 32'h80000000}, {32'h00000001, 32'h80000000}};

    if32.i_valid = 1'b0; if32.i_mode = 1'b0; if32.i_bits = '0;
    if32.i_core_done = 1'b0; if32.i_core_result = '0;
    if8.i_valid = 1'b0; if8.i_mode = 1'b0; if8.i_bits = '0;
    if8.i_core_done = 1'b0; if8.i_core_result = '0;

    // Reset held with inputs toggling: every output stays 0
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if32.i_valid = 1'($urandom_range(0, 1));
      if32.i_bits  = 4'($urandom_range(0, 15));
      if8.i_valid  = 1'($urandom_range(0, 1));
      if8.i_bits   = 2'($urandom_range(0, 3));
      check("reset_flags32", {if32.o_valid, if32.o_bits, if32.o_core_start, if32.o_core_mode,
                              if32.o_busy, if32.o_err}, '0);
    end
    check("reset_operands32", if32.o_core_operands, '0);
    check("reset_flags8", {if8.o_valid, if8.o_bits, if8.o_core_start, if8.o_busy, if8.o_err}, '0);
    @(negedge clk);
    if32.i_valid = 1'b0; if32.i_bits = '0;
    if8.i_valid  = 1'b0; if8.i_bits  = '0;
    rst = 1'b1;
    @(negedge clk);

    // Table of nominal frames
    for (int i = 0; i < 4; i++) begin
      nominal32(vecs[i]);
      @(negedge clk);
    end

    // Short frame: 17 bits then i_valid low
    e0 = err32; s0 = start32;
    for (int b = 0; b < 17; b++) begin
      if32.i_valid = 1'b1;
      if32.i_bits  = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    if32.i_valid = 1'b0;
    if32.i_bits  = '0;
    @(negedge clk);
    check("short err_pulse", if32.o_err, 1'b1);
    check("short busy", if32.o_busy, 1'b0);
    @(negedge clk);
    check("short err_1cyc", if32.o_err, 1'b0);
    check("short no_start", start32 - s0, 0);
    check("short err_count", err32 - e0, 1);
    @(negedge clk);

    // Overlap: new i_valid edge while waiting for the core
    e0 = err32;
    send_frame32(vecs[0].mode, vecs[0].ops);
    if32.i_valid = 1'b0;
    @(negedge clk);
    if32.i_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if32.i_valid = 1'b0;
    respond32("overlap", vecs[0].res, vecs[0].exp);
    check("overlap err_count", err32 - e0, 1);
    check("overlap operands", if32.o_core_operands, vecs[0].ops);
    @(negedge clk);
    check("overlap dropped", if32.o_busy, 1'b0);

    // Back-to-back: i_valid held 40 cycles gives one frame, then an immediate retry
    e0 = err32; s0 = start32;
    send_frame32(vecs[2].mode, vecs[2].ops);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) check("b2b start", if32.o_core_start, 1'b1);
      if32.i_valid = 1'b1;
      if32.i_bits  = '1;
      @(negedge clk);
    end
    if32.i_valid = 1'b0;
    if32.i_bits  = '0;
    check("b2b operands", if32.o_core_operands, vecs[2].ops);
    respond32("b2b", vecs[2].res, vecs[2].exp);
    check("b2b single_frame", start32 - s0, 1);
    nominal32(vecs[3]);
    check("b2b err_count", err32 - e0, 0);
    @(negedge clk);

    // Reset asserted in the middle of SEND
    send_frame32(vecs[0].mode, vecs[0].ops);
    if32.i_valid = 1'b0;
    @(negedge clk);
    if32.i_core_done = 1'b1; if32.i_core_result = vecs[0].res;
    @(negedge clk);
    if32.i_core_done = 1'b0; if32.i_core_result = '0;
    repeat (5) @(negedge clk);
    check("rst_mid sending", if32.o_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid valid_drop", if32.o_valid, 1'b0);
    check("rst_mid busy_drop", {if32.o_busy, if32.o_bits}, '0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (if32.o_valid || if32.o_busy) seen++;
    end
    check("rst_mid no_partial", seen, 0);
    check("rst_mid operands", if32.o_core_operands, '0);

    // WIDTH=8, IN_LANES=2 instance: p=FB, x=CD, result x=EF, y=EE
    ops8 = 16'hCDFB;
    for (int b = W8 - 1; b >= 0; b--) begin
      if8.i_valid = 1'b1;
      for (int k = 0; k < NI8; k++) if8.i_bits[k] = ops8[k*W8 + b];
      @(negedge clk);
    end
    if8.i_valid = 1'b0;
    if8.i_bits  = '0;
    check("w8 start", if8.o_core_start, 1'b1);
    check("w8 operands", if8.o_core_operands, 16'hCDFB);
    @(negedge clk);
    if8.i_core_done = 1'b1; if8.i_core_result = 16'hEEEF;
    @(negedge clk);
    if8.i_core_done = 1'b0; if8.i_core_result = '0;
    check("w8 latency", if8.o_valid, 1'b1);
    n = 0; w0 = '0; w1 = '0;
    while (if8.o_valid && n < W8 + 8) begin
      w0 = {w0[6:0], if8.o_bits[0]};
      w1 = {w1[6:0], if8.o_bits[1]};
      n++;
      @(negedge clk);
    end
    check("w8 valid_len", n, W8);
    check("w8 lane0", w0, 8'hEF);
    check("w8 lane1", w1, 8'hEE);
    check("w8 idle_after", if8.o_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
